// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the mem_bus N-master / M-slave arbiter.
// Slave decode works on fixed 32-bit fields so one function serves every parameterisation.
package mem_bus_arbiter_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int WMASK_W    = DEF_DATA_W / 8;
  localparam int MAX_SLAVES = 4;
  localparam int DEC_W      = 32;
  localparam int SLV_IDX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_UNMAPPED = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                 hit;
    logic [SLV_IDX_W-1:0] idx;
  } slave_sel_t;

  // Walk from the top index down so the lowest matching slave is the one left standing.
  function automatic slave_sel_t decode_slave(
    input logic [DEC_W-1:0]            addr,
    input logic [MAX_SLAVES*DEC_W-1:0] base,
    input logic [MAX_SLAVES*DEC_W-1:0] mask,
    input int                          num_slaves
  );
    slave_sel_t sel;
    sel = '0;
    for (int s = MAX_SLAVES - 1; s >= 0; s--) begin
      if ((s < num_slaves) && ((addr & mask[s*DEC_W +: DEC_W]) == base[s*DEC_W +: DEC_W])) begin
        sel.hit = 1'b1;
        sel.idx = SLV_IDX_W'(s);
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_chk.sv
// Protocol checker: a master must keep requesting while its slave request is outstanding.
module mem_bus_arbiter_chk #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3
) (
  input logic                   clk,
  input logic                   reset,
  input logic [NUM_MASTERS-1:0] m_request,
  input logic [NUM_MASTERS-1:0] grant,
  input logic [NUM_SLAVES-1:0]  s_request
);

  a_request_held : assert property (@(posedge clk) disable iff (reset)
    (|s_request) |-> (|(grant & m_request)))
    else $error("granted master dropped its request before ack");

  a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant))
    else $error("grant is not one-hot");

endmodule

// File: rtl/mem_bus_arbiter_rr_priority_picker.sv
// Combinational one-hot picker: first candidate at or after the pointer (round-robin)
// or the lowest-index candidate (fixed priority).
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     cand_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             rr_mode_i,
  output logic [N-1:0]     win_o
);

  // Scan candidates in priority order and keep only the first one seen.
  always_comb begin : pick
    int   idx;
    logic found;
    logic take;
    win_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx        = rr_mode_i ? ((int'(ptr_i) + i) % N) : i;
      take       = !found && cand_i[idx];
      win_o[idx] = take;
      found      = found | take;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus arbiter: selects one master per transaction, decodes its address to a slave,
// routes the handshake and keeps the grant for bounded zero-bubble bursts.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_W      = 27,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RR_MODE     = 1,
  parameter int MAX_BURST   = 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {27'h600_0000, 27'h400_0000, 27'h000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {27'h700_0000, 27'h600_0000, 27'h400_0000}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_request,
  input  logic [NUM_MASTERS-1:0]            m_urgent,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_wmask,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_address,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [DATA_W-1:0]                 m_rdata,
  output logic [NUM_SLAVES-1:0]             s_request,
  output logic                              s_write,
  output logic [DATA_W/8-1:0]               s_wmask,
  output logic [ADDR_W-1:0]                 s_address,
  output logic [DATA_W-1:0]                 s_wdata,
  input  logic [NUM_SLAVES-1:0]             s_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0]      s_rdata,
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              unmapped_error
);

  localparam int MW     = DATA_W / 8;
  localparam int MIDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int BC_W   = $clog2(MAX_BURST + 1);

  arb_state_e              state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [MIDX_W-1:0]       rr_q, rr_d;
  logic [BC_W-1:0]         burst_q, burst_d;
  logic                    post_ack_q, post_ack_d;

  logic [NUM_MASTERS-1:0]  urgent_req_s, cand_s, win_s;
  logic [MIDX_W-1:0]       g_idx_s, w_idx_s;
  logic [ADDR_W-1:0]       addr_s;
  logic [MAX_SLAVES*DEC_W-1:0] base_ext_s, mask_ext_s;
  slave_sel_t              dec_s;
  logic                    cont_s;
  logic [NUM_SLAVES-1:0]   s_req_s;
  logic [NUM_MASTERS-1:0]  m_ack_s;
  logic [DATA_W-1:0]       m_rdata_s;
  logic                    unmapped_s;

  assign urgent_req_s = m_request & m_urgent;
  assign cand_s       = (|urgent_req_s) ? urgent_req_s : m_request;

  rr_priority_picker #(
    .N     (NUM_MASTERS),
    .PTR_W (MIDX_W)
  ) u_picker (
    .cand_i    (cand_s),
    .ptr_i     (rr_q),
    .rr_mode_i (RR_MODE != 0),
    .win_o     (win_s)
  );

  // One-hot to index for the current grant and the arbitration winner.
  always_comb begin
    g_idx_s = '0;
    w_idx_s = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      g_idx_s = g_idx_s | (grant_q[i] ? MIDX_W'(i) : '0);
      w_idx_s = w_idx_s | (win_s[i]   ? MIDX_W'(i) : '0);
    end
  end

  // Widen the region table into the decode helper's fixed field layout.
  always_comb begin
    base_ext_s = '0;
    mask_ext_s = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      base_ext_s[s*DEC_W +: DEC_W] = DEC_W'(SLAVE_BASE[s*ADDR_W +: ADDR_W]);
      mask_ext_s[s*DEC_W +: DEC_W] = DEC_W'(SLAVE_MASK[s*ADDR_W +: ADDR_W]);
    end
  end

  assign addr_s = m_address[g_idx_s*ADDR_W +: ADDR_W];
  assign dec_s  = decode_slave(DEC_W'(addr_s), base_ext_s, mask_ext_s, NUM_SLAVES);

  // A burst continues only if the owner asks again, has budget left and nobody else is urgent.
  assign cont_s = (|(grant_q & m_request)) && (burst_q < BC_W'(MAX_BURST)) &&
                  !(|(urgent_req_s & ~grant_q));

  // State, grant, round-robin pointer and burst counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      burst_q    <= '0;
      post_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      burst_q    <= burst_d;
      post_ack_q <= post_ack_d;
    end
  end

  // Next-state and handshake routing.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    burst_d    = burst_q;
    post_ack_d = post_ack_q;
    s_req_s    = '0;
    m_ack_s    = '0;
    m_rdata_s  = '0;
    unmapped_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|m_request) begin
          grant_d    = win_s;
          rr_d       = (w_idx_s == MIDX_W'(NUM_MASTERS - 1)) ? '0 : w_idx_s + MIDX_W'(1);
          burst_d    = '0;
          post_ack_d = 1'b0;
          state_d    = ST_ACCESS;
        end else begin
          grant_d = '0;
        end
      end
      ST_ACCESS: begin
        if (post_ack_q && !cont_s) begin
          grant_d    = '0;
          burst_d    = '0;
          post_ack_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (!dec_s.hit) begin
          post_ack_d = 1'b0;
          state_d    = ST_UNMAPPED;
        end else begin
          s_req_s[dec_s.idx] = 1'b1;
          if (s_ack[dec_s.idx]) begin
            m_ack_s    = grant_q;
            m_rdata_s  = s_rdata[dec_s.idx*DATA_W +: DATA_W];
            burst_d    = burst_q + BC_W'(1);
            post_ack_d = 1'b1;
          end else begin
            post_ack_d = 1'b0;
          end
        end
      end
      ST_UNMAPPED: begin
        m_ack_s    = grant_q;
        unmapped_s = 1'b1;
        burst_d    = burst_q + BC_W'(1);
        post_ack_d = 1'b1;
        state_d    = ST_ACCESS;
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        burst_d    = '0;
        post_ack_d = 1'b0;
      end
    endcase
  end

  assign grant          = grant_q;
  assign s_request      = s_req_s;
  assign m_ack          = m_ack_s;
  assign m_rdata        = m_rdata_s;
  assign unmapped_error = unmapped_s;
  assign s_write        = (|grant_q) ? m_write[g_idx_s] : 1'b0;
  assign s_wmask        = (|grant_q) ? m_wmask[g_idx_s*MW +: MW] : '0;
  assign s_address      = (|grant_q) ? addr_s : '0;
  assign s_wdata        = (|grant_q) ? m_wdata[g_idx_s*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two instances (burst limit 4 and 1) share master stimulus.
module tb_mem_bus_arbiter;

  localparam int NM  = 4;
  localparam int NS  = 3;
  localparam int AW  = 27;
  localparam int DW  = 16;
  localparam int MWB = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NM-1:0]     m_request, m_urgent, m_write;
  logic [NM*MWB-1:0] m_wmask;
  logic [NM*AW-1:0]  m_address;
  logic [NM*DW-1:0]  m_wdata;
  logic [NS*DW-1:0]  s_rdata;
  logic              auto_ack;
  logic [NS-1:0]     man_ack;

  logic [NM-1:0]  m_ack_a, m_ack_b, grant_a, grant_b;
  logic [DW-1:0]  m_rdata_a, m_rdata_b, s_wdata_a, s_wdata_b;
  logic [NS-1:0]  s_request_a, s_request_b, s_ack_a, s_ack_b;
  logic           s_write_a, s_write_b, unmapped_a, unmapped_b;
  logic [MWB-1:0] s_wmask_a, s_wmask_b;
  logic [AW-1:0]  s_address_a, s_address_b;

  assign s_ack_a = auto_ack ? s_request_a : man_ack;
  assign s_ack_b = auto_ack ? s_request_b : man_ack;

  mem_bus_arbiter #(.RR_MODE(1), .MAX_BURST(4)) dut_a (
    .clk(clk), .reset(reset), .m_request(m_request), .m_urgent(m_urgent), .m_write(m_write),
    .m_wmask(m_wmask), .m_address(m_address), .m_wdata(m_wdata), .m_ack(m_ack_a),
    .m_rdata(m_rdata_a), .s_request(s_request_a), .s_write(s_write_a), .s_wmask(s_wmask_a),
    .s_address(s_address_a), .s_wdata(s_wdata_a), .s_ack(s_ack_a), .s_rdata(s_rdata),
    .grant(grant_a), .unmapped_error(unmapped_a)
  );

  mem_bus_arbiter #(.RR_MODE(1), .MAX_BURST(1)) dut_b (
    .clk(clk), .reset(reset), .m_request(m_request), .m_urgent(m_urgent), .m_write(m_write),
    .m_wmask(m_wmask), .m_address(m_address), .m_wdata(m_wdata), .m_ack(m_ack_b),
    .m_rdata(m_rdata_b), .s_request(s_request_b), .s_write(s_write_b), .s_wmask(s_wmask_b),
    .s_address(s_address_b), .s_wdata(s_wdata_b), .s_ack(s_ack_b), .s_rdata(s_rdata),
    .grant(grant_b), .unmapped_error(unmapped_b)
  );

  mem_bus_arbiter_chk chk_a (.clk(clk), .reset(reset), .m_request(m_request), .grant(grant_a), .s_request(s_request_a));
  mem_bus_arbiter_chk chk_b (.clk(clk), .reset(reset), .m_request(m_request), .grant(grant_b), .s_request(s_request_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Land 2 time units after the active edge; inputs change here, outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    m_request = '0;
    m_urgent  = '0;
    m_write   = '0;
    m_wmask   = '1;
    m_address = '0;
    m_wdata   = '0;
    auto_ack  = 1'b0;
    man_ack   = '0;
    tick();
    reset = 1'b0;
  endtask

  logic [NM-1:0] rr_seq [5];
  logic [NM-1:0] rr_exp [5];
  logic          bu_ack [7];
  logic [NM-1:0] bu_gnt [7];
  int            n_seen;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    s_rdata = {16'h3333, 16'h2222, 16'hBEEF};
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bu_ack  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bu_gnt  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};

    // Reset state
    do_reset();
    #1;
    check_eq("rst_grant", grant_a, 4'b0000);
    check_eq("rst_sreq", s_request_a, 3'b000);
    check_eq("rst_mack", m_ack_a, 4'b0000);
    check_eq("rst_unmapped", unmapped_a, 1'b0);

    // Single master 1 read of slave 0, slave answers two cycles after request
    do_reset();
    m_address[1*AW +: AW] = 27'h000_0100;
    m_request = 4'b0010;
    #1 check_eq("t1_idle_sreq", s_request_a, 3'b000);
    tick(); #1;
    check_eq("t1_sreq", s_request_a, 3'b001);
    check_eq("t1_grant", grant_a, 4'b0010);
    check_eq("t1_addr", s_address_a, 27'h000_0100);
    tick(); #1;
    check_eq("t1_wait_ack", m_ack_a, 4'b0000);
    tick();
    man_ack = 3'b001;
    #1;
    check_eq("t1_mack", m_ack_a, 4'b0010);
    check_eq("t1_rdata", m_rdata_a, 16'hBEEF);
    tick();
    man_ack = '0;
    m_request = '0;
    #1 check_eq("t1_post_sreq", s_request_a, 3'b000);
    tick(); #1;
    check_eq("t1_release", grant_a, 4'b0000);

    // Round-robin rotation with a burst limit of 1
    do_reset();
    m_request = 4'b1111;
    auto_ack  = 1'b1;
    n_seen    = 0;
    for (int i = 0; i < 5; i++) rr_seq[i] = '0;
    for (int k = 0; k < 40 && n_seen < 5; k++) begin
      tick(); #1;
      if (m_ack_b != '0) begin
        rr_seq[n_seen] = m_ack_b;
        n_seen++;
      end
    end
    check_eq("rr_count", n_seen, 5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("rr_order%0d", i), rr_seq[i], rr_exp[i]);

    // Master 2 streams writes with a burst limit of 4
    do_reset();
    m_write   = 4'b0100;
    m_wdata[2*DW +: DW] = 16'h1234;
    m_request = 4'b0100;
    auto_ack  = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick(); #1;
      check_eq($sformatf("burst_ack%0d", k), m_ack_a[2], bu_ack[k]);
      check_eq($sformatf("burst_gnt%0d", k), grant_a, bu_gnt[k]);
      if (k == 0) begin
        check_eq("burst_write", s_write_a, 1'b1);
        check_eq("burst_wdata", s_wdata_a, 16'h1234);
        check_eq("burst_wmask", s_wmask_a, 2'b11);
      end
    end

    // Urgent request from master 1 preempts master 3's burst
    do_reset();
    m_request = 4'b1000;
    auto_ack  = 1'b1;
    tick(); #1 check_eq("urg_ack1", m_ack_a, 4'b1000);
    tick(); #1 check_eq("urg_ack2", m_ack_a, 4'b1000);
    tick();
    m_request = 4'b1010;
    m_urgent  = 4'b0010;
    #1;
    check_eq("urg_release_ack", m_ack_a, 4'b0000);
    check_eq("urg_release_gnt", grant_a, 4'b1000);
    tick(); #1 check_eq("urg_idle_gnt", grant_a, 4'b0000);
    tick(); #1;
    check_eq("urg_new_gnt", grant_a, 4'b0010);
    check_eq("urg_new_ack", m_ack_a, 4'b0010);

    // Unmapped address
    do_reset();
    m_address[0 +: AW] = 27'h7FF_FFFF;
    m_request = 4'b0001;
    tick(); #1;
    check_eq("um_gnt", grant_a, 4'b0001);
    check_eq("um_sreq0", s_request_a, 3'b000);
    check_eq("um_mack0", m_ack_a, 4'b0000);
    tick(); #1;
    check_eq("um_mack", m_ack_a, 4'b0001);
    check_eq("um_err", unmapped_a, 1'b1);
    check_eq("um_rdata", m_rdata_a, 16'h0000);
    check_eq("um_sreq", s_request_a, 3'b000);
    tick();
    m_request = '0;
    #1;
    check_eq("um_err_pulse", unmapped_a, 1'b0);
    check_eq("um_mack_pulse", m_ack_a, 4'b0000);

    // Reset during an outstanding access, slave ack arrives afterwards
    do_reset();
    m_request = 4'b0001;
    tick(); #1 check_eq("rs_pre_sreq", s_request_a, 3'b001);
    tick();
    reset = 1'b1;
    #1;
    check_eq("rs_gnt", grant_a, 4'b0000);
    check_eq("rs_sreq", s_request_a, 3'b000);
    m_request = '0;
    tick();
    reset   = 1'b0;
    man_ack = 3'b001;
    #1 check_eq("rs_late_ack", m_ack_a, 4'b0000);
    tick(); #1;
    check_eq("rs_idle_gnt", grant_a, 4'b0000);
    check_eq("rs_idle_ack", m_ack_a, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
